partition_sweep_checker: RTL

Sequential exhaustive-sweep engine for partition characterisation. Drives every input vector of a PI_W-input partition in ascending order, takes the exact and approximate partition outputs back, and accumulates error metrics: mismatch count, Hamming-distance sum and optional maximum absolute error. Sits next to the partition pair: it produces the partition's `pi` stimulus and consumes its `po` responses, replacing the per-vector display dump with on-chip metrics.

---
 rtl/partition_sweep_checker.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/partition_sweep_checker.sv
// partition_sweep_checker
// Exhaustive sweep engine for characterising a PI_W-input partition pair.
// Drives every input vector on `pi` in ascending order, takes the exact and
// approximate responses back LAT cycles later, and accumulates the mismatch
// count, the Hamming-distance sum and (optionally) the maximum absolute error.
//
// Optional feature macro: SWEEP_MAX_ERR_EN
//   defined   -> max_err tracks max |po_exact - po_apx|
//   undefined -> no subtractor/comparator is built, max_err is tied to 0

module partition_sweep_checker #(
  parameter int PI_W = 7,  // partition input width  (1..16)
  parameter int PO_W = 4,  // partition output width (1..15)
  parameter int LAT  = 0   // partition response latency in cycles (0..4)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [PI_W-1:0]   pi,
  input  logic [PO_W-1:0]   po_exact,
  input  logic [PO_W-1:0]   po_apx,
  output logic [PI_W:0]     err_cnt,
  output logic [PI_W+3:0]   hd_sum,
  output logic [PO_W-1:0]   max_err
);

  localparam int EW = PI_W + 1;  // err_cnt width: up to 2^PI_W mismatches
  localparam int HW = PI_W + 4;  // hd_sum width: up to 2^PI_W * 15

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state;
  logic [2:0]      drain_cnt;
  logic            accept;
  logic            issue;
  logic            last_vec;
  logic            cmp_en;
  logic [PO_W-1:0] diff_bits;
  logic [3:0]      diff_pop;

  assign accept    = (state == S_IDLE) && start;
  assign issue     = (state == S_SWEEP);
  assign last_vec  = (pi == {PI_W{1'b1}});
  assign diff_bits = po_exact ^ po_apx;

  // Sequencer: IDLE -> SWEEP -> DRAIN (LAT cycles) -> DONE -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    if (!rst_n) begin
      state     <= S_IDLE;
      pi        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      drain_cnt <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_SWEEP;
            pi    <= '0;
            busy  <= 1'b1;
          end
        end
        S_SWEEP: begin
          if (last_vec) begin
            // pi holds at its last value; it never wraps.
            if (LAT == 0) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= S_DRAIN;
              drain_cnt <= 3'(LAT - 1);
            end
          end else begin
            pi <= pi + PI_W'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 3'd0) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Token delay line: a response is compared exactly LAT cycles after its
  // vector was issued. With LAT=0 the response belongs to the current pi.
  generate
    if (LAT == 0) begin : g_no_delay
      assign cmp_en = issue;
    end else begin : g_delay
      logic [LAT-1:0] tok_q;

      // Shift a valid token in for every issued vector.
      always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the token line is cleared on reset so an aborted sweep can
        // never leave stale tokens that would update the next sweep's metrics.
        if (!rst_n) begin
          tok_q <= '0;
        end else begin
          tok_q <= (tok_q << 1) | LAT'(issue);
        end
      end

      assign cmp_en = tok_q[LAT-1];
    end
  endgenerate

  // Population count of the response difference.
  always_comb begin
    // NOTE: blocking assignments here build a combinational adder chain; the
    // default assignment first also keeps the block free of latches.
    diff_pop = '0;
    for (int i = 0; i < PO_W; i++) begin
      diff_pop = diff_pop + 4'(diff_bits[i]);
    end
  end

  // Mismatch and Hamming accumulators: cleared on an accepted start,
  // updated whenever a token emerges, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
      hd_sum  <= '0;
    end else if (accept) begin
      err_cnt <= '0;
      hd_sum  <= '0;
    end else if (cmp_en) begin
      err_cnt <= err_cnt + EW'(|diff_bits);
      hd_sum  <= hd_sum + HW'(diff_pop);
    end
  end

`ifdef SWEEP_MAX_ERR_EN
  logic [PO_W-1:0] abs_diff;

  assign abs_diff = (po_exact >= po_apx) ? (po_exact - po_apx) : (po_apx - po_exact);

  // Running maximum of the unsigned absolute difference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_err <= '0;
    end else if (accept) begin
      max_err <= '0;
    end else if (cmp_en && (abs_diff > max_err)) begin
      max_err <= abs_diff;
    end
  end
`else
  assign max_err = '0;
`endif

endmodule
